// File: rtl/fp32_pkg.sv
// ---------------------------------------------------------------------------
// fp32_pkg
// Shared definitions for the binary32 floating-point ALU units: field widths,
// format constants and an operand classifier. Subnormal encodings are treated
// as zero everywhere in the ALU, so the classifier reports them as FP_ZERO.
// ---------------------------------------------------------------------------
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int PROD_W = 2 * MANT_W;
  localparam int EXPI_W = 10;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_NORMAL = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_e;

  // Exponent 0 covers both true zero and subnormals (flushed to zero).
  function automatic fp_class_e fp_classify(input logic [31:0] x);
    fp_class_e c;
    if (x[30:23] == 8'd0) begin
      c = FP_ZERO;
    end else if (x[30:23] == 8'hFF) begin
      c = (x[22:0] == 23'd0) ? FP_INF : FP_NAN;
    end else begin
      c = FP_NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/f_mul_if.sv
// ---------------------------------------------------------------------------
// f_mul_if
// Operand/result bundle of the floating-point multiplier.
//   EN       : capture enable (master -> multiplier)
//   A, B     : binary32 operands (master -> multiplier)
//   OUT_MUL  : registered binary32 product (multiplier -> master)
//   zero     : registered, OUT_MUL is +/-0
//   infinity : registered, OUT_MUL is +/-inf
//   Flag_Mul : registered copy of EN (result valid)
// ---------------------------------------------------------------------------
interface f_mul_if;

  logic        EN;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] OUT_MUL;
  logic        zero;
  logic        infinity;
  logic        Flag_Mul;

  modport master (
    output EN, A, B,
    input  OUT_MUL, zero, infinity, Flag_Mul
  );

  modport slave (
    input  EN, A, B,
    output OUT_MUL, zero, infinity, Flag_Mul
  );

endinterface

// File: rtl/fp32_round_norm.sv
// ---------------------------------------------------------------------------
// fp32_round_norm
// Normalizes a raw 48-bit significand product, rounds it to nearest-even and
// clamps the exponent into the binary32 normal range.
//   prod_i : 48-bit product of two 24-bit significands (hidden bits included)
//   exp_i  : signed biased exponent eA + eB - BIAS before normalization
//   mag_o  : 31-bit result magnitude {exponent, fraction}, sign excluded
//   zero_o : result underflowed to zero
//   inf_o  : result overflowed to infinity
// ---------------------------------------------------------------------------
module fp32_round_norm
  import fp32_pkg::*;
(
  input  logic        [PROD_W-1:0] prod_i,
  input  logic signed [EXPI_W-1:0] exp_i,
  output logic        [30:0]       mag_o,
  output logic                     zero_o,
  output logic                     inf_o
);

  logic        [FRAC_W-1:0] frac_trunc;
  logic                     guard_bit;
  logic                     round_bit;
  logic                     sticky_bit;
  logic                     round_up;
  logic        [MANT_W:0]   mant_rnd;
  logic        [FRAC_W-1:0] frac_final;
  logic signed [EXPI_W-1:0] exp_norm;
  logic signed [EXPI_W-1:0] exp_final;

  always_comb begin
    frac_trunc = '0;
    guard_bit  = 1'b0;
    round_bit  = 1'b0;
    sticky_bit = 1'b0;
    exp_norm   = exp_i;
    frac_final = '0;
    exp_final  = exp_i;
    mag_o      = '0;
    zero_o     = 1'b0;
    inf_o      = 1'b0;

    // Product of two [1,2) significands lies in [1,4); bit 47 marks [2,4).
    if (prod_i[PROD_W-1]) begin
      frac_trunc = prod_i[46:24];
      guard_bit  = prod_i[23];
      round_bit  = prod_i[22];
      sticky_bit = |prod_i[21:0];
      exp_norm   = exp_i + 10'sd1;
    end else begin
      frac_trunc = prod_i[45:23];
      guard_bit  = prod_i[22];
      round_bit  = prod_i[21];
      sticky_bit = |prod_i[20:0];
      exp_norm   = exp_i;
    end

    // Ties go to the even neighbour, so an exact half only rounds up when
    // the kept LSB is odd.
    round_up = guard_bit & (round_bit | sticky_bit | frac_trunc[0]);
    mant_rnd = {2'b01, frac_trunc} + {{MANT_W{1'b0}}, round_up};

    // A carry out of rounding means the significand became exactly 2.0.
    if (mant_rnd[MANT_W]) begin
      frac_final = mant_rnd[MANT_W-1:1];
      exp_final  = exp_norm + 10'sd1;
    end else begin
      frac_final = mant_rnd[FRAC_W-1:0];
      exp_final  = exp_norm;
    end

    if (exp_final >= 10'sd255) begin
      mag_o = POS_INF[30:0];
      inf_o = 1'b1;
    end else if (exp_final <= 10'sd0) begin
      mag_o  = '0;
      zero_o = 1'b1;
    end else begin
      mag_o = {exp_final[EXP_W-1:0], frac_final};
    end
  end

endmodule

// File: rtl/f_mul.sv
// ---------------------------------------------------------------------------
// f_mul
// Single-precision multiplier for the floating-point ALU. The product of A
// and B is computed combinationally and captured into one output register
// bank whenever EN is high; otherwise the result and flags hold.
//   CLK : rising-edge clock
//   RST : asynchronous active-low reset (clears all outputs)
//   bus : f_mul_if slave modport (EN, A, B in; OUT_MUL, zero, infinity,
//         Flag_Mul out)
// ---------------------------------------------------------------------------
module f_mul
  import fp32_pkg::*;
(
  input logic     CLK,
  input logic     RST,
  f_mul_if.slave  bus
);

  fp_class_e                class_a;
  fp_class_e                class_b;
  logic                     sign_res;
  logic        [MANT_W-1:0] mant_a;
  logic        [MANT_W-1:0] mant_b;
  logic        [PROD_W-1:0] prod;
  logic signed [EXPI_W-1:0] exp_sum;

  logic        [30:0]       rn_mag;
  logic                     rn_zero;
  logic                     rn_inf;

  logic        [31:0]       res_word;
  logic                     res_zero;
  logic                     res_inf;

  logic        [31:0]       out_mul_d, out_mul_q;
  logic                     zero_d,    zero_q;
  logic                     inf_d,     inf_q;
  logic                     flag_d,    flag_q;

  // Operand decode, significand product and unnormalized biased exponent.
  always_comb begin
    class_a  = fp_classify(bus.A);
    class_b  = fp_classify(bus.B);
    sign_res = bus.A[31] ^ bus.B[31];
    mant_a   = {1'b1, bus.A[FRAC_W-1:0]};
    mant_b   = {1'b1, bus.B[FRAC_W-1:0]};
    prod     = {{MANT_W{1'b0}}, mant_a} * {{MANT_W{1'b0}}, mant_b};
    // Both exponents are 1..254 on the normal path, so the sum minus the
    // bias spans -125..381 and fits a 10-bit signed value.
    exp_sum  = $signed({2'b00, bus.A[30:23]} + {2'b00, bus.B[30:23]}
                       - 10'(BIAS));
  end

  fp32_round_norm u_round_norm (
    .prod_i (prod),
    .exp_i  (exp_sum),
    .mag_o  (rn_mag),
    .zero_o (rn_zero),
    .inf_o  (rn_inf)
  );

  // Special-case priority: NaN (including inf*0) beats infinity beats zero;
  // only two normal operands take the rounded datapath result.
  always_comb begin
    res_word = '0;
    res_zero = 1'b0;
    res_inf  = 1'b0;

    if ((class_a == FP_NAN) || (class_b == FP_NAN) ||
        ((class_a == FP_INF) && (class_b == FP_ZERO)) ||
        ((class_a == FP_ZERO) && (class_b == FP_INF))) begin
      res_word = QNAN;
    end else if ((class_a == FP_INF) || (class_b == FP_INF)) begin
      res_word = {sign_res, POS_INF[30:0]};
      res_inf  = 1'b1;
    end else if ((class_a == FP_ZERO) || (class_b == FP_ZERO)) begin
      res_word = {sign_res, 31'd0};
      res_zero = 1'b1;
    end else begin
      res_word = {sign_res, rn_mag};
      res_zero = rn_zero;
      res_inf  = rn_inf;
    end
  end

  // Capture on EN, otherwise hold; the valid flag simply follows EN.
  always_comb begin
    out_mul_d = out_mul_q;
    zero_d    = zero_q;
    inf_d     = inf_q;
    flag_d    = bus.EN;
    if (bus.EN) begin
      out_mul_d = res_word;
      zero_d    = res_zero;
      inf_d     = res_inf;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_mul_q <= '0;
      zero_q    <= 1'b0;
      inf_q     <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      out_mul_q <= out_mul_d;
      zero_q    <= zero_d;
      inf_q     <= inf_d;
      flag_q    <= flag_d;
    end
  end

  assign bus.OUT_MUL  = out_mul_q;
  assign bus.zero     = zero_q;
  assign bus.infinity = inf_q;
  assign bus.Flag_Mul = flag_q;

endmodule

// File: tb/tb_f_mul.sv
// ---------------------------------------------------------------------------
// tb_f_mul
// Self-checking bench for f_mul: directed special/boundary products, an
// enable-hold sequence, an asynchronous reset pulse and randomized operands,
// all compared against an integer-arithmetic reference of binary32 multiply.
// ---------------------------------------------------------------------------
module tb_f_mul;

  logic clk;
  logic rst_n;

  f_mul_if bus ();

  f_mul dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_out;
  logic        exp_zero;
  logic        exp_inf;
  logic        exp_flag;

  // Reference: exact integer product, rounded by comparing the discarded
  // remainder with one half ulp.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z,
                                  output logic inf);
    int     ea, eb, e, sh;
    longint ma, mb, p, q, rem, half;
    logic   s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    r = 32'd0; z = 1'b0; inf = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      r = {s, 8'hFF, 23'd0}; inf = 1'b1;
    end else if (a_zero || b_zero) begin
      r = {s, 31'd0}; z = 1'b1;
    end else begin
      ma = longint'(a[22:0]) + 64'd8388608;
      mb = longint'(b[22:0]) + 64'd8388608;
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24; e = e + 1;
      end else begin
        sh = 23;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1; e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; inf = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'd0}; z = 1'b1;
      end else begin
        r = {s, 8'(e), q[22:0]};
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out"},  bus.OUT_MUL, exp_out);
    check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, exp_zero});
    check({tag, ".inf"},  {31'd0, bus.infinity}, {31'd0, exp_inf});
    check({tag, ".flag"}, {31'd0, bus.Flag_Mul}, {31'd0, exp_flag});
  endtask

  // Drive at the falling edge, let the rising edge capture, sample 1ns later.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic en, input string tag);
    logic [31:0] r;
    logic        z, i;
    @(negedge clk);
    bus.A  = a;
    bus.B  = b;
    bus.EN = en;
    @(posedge clk);
    #1;
    exp_flag = en;
    if (en) begin
      ref_mul(a, b, r, z, i);
      exp_out  = r;
      exp_zero = z;
      exp_inf  = i;
    end
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    int          kind;
    x    = $urandom;
    kind = $urandom_range(0, 11);
    case (kind)
      0:       x[30:23] = 8'h00;
      1:       begin x[30:23] = 8'hFF; x[22:0] = 23'd0; end
      2:       x[30:23] = 8'hFF;
      3:       x[30:23] = 8'($urandom_range(1, 6));
      4:       x[30:23] = 8'($urandom_range(248, 254));
      5:       x[22:0] = 23'h7FFFFF;
      default: x[30:23] = 8'($urandom_range(90, 164));
    endcase
    if (x[30:23] == 8'hFF && kind == 2 && x[22:0] == 23'd0) x[0] = 1'b1;
    return x;
  endfunction

  initial begin
    bus.EN = 1'b0;
    bus.A  = 32'd0;
    bus.B  = 32'd0;
    exp_out  = 32'd0;
    exp_zero = 1'b0;
    exp_inf  = 1'b0;
    exp_flag = 1'b0;

    // Held in reset with live operands and EN: outputs must stay cleared.
    rst_n = 1'b0;
    #2;
    bus.EN = 1'b1;
    bus.A  = 32'h41B2_6666;
    bus.B  = 32'h3F80_0000;
    @(posedge clk);
    #1;
    check_outputs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(32'h3FC0_0000, 32'h4000_0000, 1'b1, "first_capture");
    apply_stimulus(32'h7F80_0000, 32'h404C_CCCC, 1'b1, "inf_x_pos");
    apply_stimulus(32'hFF80_0000, 32'hC04C_CCCC, 1'b1, "ninf_x_neg");
    apply_stimulus(32'h0000_0000, 32'h404C_CCCC, 1'b1, "zero_x_pos");
    apply_stimulus(32'h7F80_0000, 32'h0000_0000, 1'b1, "inf_x_zero");
    apply_stimulus(32'h7FA0_0001, 32'h3F80_0000, 1'b1, "nan_in");
    apply_stimulus(32'h41B2_6666, 32'hBF00_0000, 1'b1, "p22_3_x_mhalf");
    check("p22_3_const", bus.OUT_MUL, 32'hC132_6666);
    apply_stimulus(32'hC0CC_CCCC, 32'hBF00_0000, 1'b1, "m6_4_x_mhalf");
    check("m6_4_const", bus.OUT_MUL, 32'h404C_CCCC);
    apply_stimulus(32'h40CC_CCCC, 32'hBF00_0000, 1'b1, "p6_4_x_mhalf");
    check("p6_4_const", bus.OUT_MUL, 32'hC04C_CCCC);
    apply_stimulus(32'h7F00_0000, 32'h4000_0000, 1'b1, "overflow");
    apply_stimulus(32'h0080_0000, 32'h3F00_0000, 1'b1, "underflow");
    apply_stimulus(32'h3F80_0001, 32'h3F80_0001, 1'b1, "round_sticky");
    apply_stimulus(32'h3FFF_FFFF, 32'h3FFF_FFFF, 1'b1, "round_carry");
    apply_stimulus(32'h7F7F_FFFF, 32'h3F80_0001, 1'b1, "round_to_ovf");

    // Enable dropped for two cycles while operands change.
    apply_stimulus(32'h4040_0000, 32'h4040_0000, 1'b1, "pre_hold");
    apply_stimulus(32'h4100_0000, 32'h4200_0000, 1'b0, "hold1");
    apply_stimulus(32'hC100_0000, 32'h3E00_0000, 1'b0, "hold2");
    check("hold_const", bus.OUT_MUL, 32'h4110_0000);
    apply_stimulus(32'h4100_0000, 32'h4200_0000, 1'b1, "resume");

    // Asynchronous reset pulse between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_out  = 32'd0;
    exp_zero = 1'b0;
    exp_inf  = 1'b0;
    exp_flag = 1'b0;
    check_outputs("async_reset");
    bus.EN = 1'b0;
    #1;
    rst_n = 1'b1;
    apply_stimulus(32'h4000_0000, 32'h4000_0000, 1'b0, "post_reset_idle");
    apply_stimulus(32'h4000_0000, 32'h4000_0000, 1'b1, "post_reset_cap");

    for (int n = 0; n < 250; n++) begin
      apply_stimulus(rand_operand(), rand_operand(),
                     ($urandom_range(0, 4) != 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
